// File: rtl/tcb_infer_sched.sv
// rtl/tcb_infer_sched.sv - frame scheduler between the image loader and top_tcb_121_16_10
// Optional watchdog: define TCB_SCHED_TIMEOUT_EN to bound each inference to TO_CYC cycles in WAIT.
module tcb_infer_sched #(
   parameter int PIX_W  = 8,
   parameter int N_PIX  = 121,
   parameter int CLS_W  = 4,
   parameter int CNT_W  = 16,
   parameter int TO_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_PIX*PIX_W-1:0] s_img,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [N_PIX*PIX_W-1:0] img_source,
   output logic                   valid_top,
   input  logic                   ready_top,
   input  logic [CLS_W-1:0]       number,
   output logic [CLS_W-1:0]       m_class,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [CNT_W-1:0]       frame_cnt,
   output logic                   busy,
   output logic                   timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t state;

`ifdef TCB_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TO_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TO_CYC - 1);
   logic [WD_W-1:0] wd_cnt;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         s_ready    <= 1'b1;
         valid_top  <= 1'b0;
         m_valid    <= 1'b0;
         busy       <= 1'b0;
         img_source <= '0;
         m_class    <= '0;
         frame_cnt  <= '0;
`ifdef TCB_SCHED_TIMEOUT_EN
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               // s_ready is registered high in IDLE, so s_valid alone completes the accept
               if (s_valid) begin
                  img_source <= s_img;
                  s_ready    <= 1'b0;
                  valid_top  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               valid_top <= 1'b0;
`ifdef TCB_SCHED_TIMEOUT_EN
               wd_cnt    <= '0;
`endif
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ready_top) begin
                  m_class <= number;
                  m_valid <= 1'b1;
                  state   <= ST_HOLD;
               end
`ifdef TCB_SCHED_TIMEOUT_EN
               // a real result on the limit cycle takes priority over the timeout
               else if (wd_cnt == WD_MAX) begin
                  m_class     <= '1;
                  m_valid     <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= ST_HOLD;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            ST_HOLD: begin
               if (m_ready) begin
                  m_valid   <= 1'b0;
                  s_ready   <= 1'b1;
                  busy      <= 1'b0;
                  frame_cnt <= frame_cnt + CNT_W'(1);
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifndef TCB_SCHED_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tcb_infer_sched.sv
// tb/tb_tcb_infer_sched.sv - randomized scoreboard bench for tcb_infer_sched
// Watchdog frames are exercised when TCB_SCHED_TIMEOUT_EN is defined.
module tb_tcb_infer_sched;
   localparam int PIX_W  = 8;
   localparam int N_PIX  = 121;
   localparam int CLS_W  = 4;
   localparam int CNT_W  = 4;
   localparam int TO_CYC = 16;
   localparam int IMG_W  = PIX_W * N_PIX;

   typedef logic [IMG_W-1:0] img_t;
   typedef struct {
      logic [CLS_W-1:0] cls;
      logic             to;
   } res_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   img_t             s_img = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   img_t             img_source;
   logic             valid_top;
   logic             ready_top = 1'b0;
   logic [CLS_W-1:0] number = '0;
   logic [CLS_W-1:0] m_class;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [CNT_W-1:0] frame_cnt;
   logic             busy;
   logic             timeout_err;

   res_t exp_res[$];
   img_t exp_img[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   logic exp_to = 1'b0;
   img_t pend_img;

   tcb_infer_sched #(
      .PIX_W(PIX_W), .N_PIX(N_PIX), .CLS_W(CLS_W), .CNT_W(CNT_W), .TO_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst_n), .s_img(s_img), .s_valid(s_valid), .s_ready(s_ready),
      .img_source(img_source), .valid_top(valid_top), .ready_top(ready_top),
      .number(number), .m_class(m_class), .m_valid(m_valid), .m_ready(m_ready),
      .frame_cnt(frame_cnt), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic img_t rand_img();
      img_t r;
      for (int i = 0; i < N_PIX; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every downstream handshake is scored against the queued expectation
   logic             cnt_pend = 1'b0;
   logic             hold_prev = 1'b0;
   logic [CLS_W-1:0] cls_prev = '0;
   res_t             mr;
   img_t             mi;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_res.delete();
         exp_img.delete();
         exp_cnt   = 0;
         exp_to    = 1'b0;
         cnt_pend  = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (cnt_pend) begin
            chk("frame_cnt", frame_cnt, exp_cnt);
            cnt_pend = 1'b0;
         end
         if (m_valid) begin
            chk("s_ready_hold", s_ready, 0);
            if (hold_prev) chk("m_class_stable", m_class, cls_prev);
            hold_prev = 1'b1;
            cls_prev  = m_class;
            if (m_ready) begin
               hold_prev = 1'b0;
               if (exp_res.size() == 0 || exp_img.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: m_class %0h with nothing expected", m_class);
               end else begin
                  mr = exp_res.pop_front();
                  mi = exp_img.pop_front();
                  chk("m_class", m_class, mr.cls);
                  exp_to = exp_to | mr.to;
                  chk("timeout_err", timeout_err, exp_to);
                  checks++;
                  if (img_source !== mi) begin
                     errors++;
                     $display("FAIL img_source: low word %0h expected %0h", img_source[31:0], mi[31:0]);
                  end
                  exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
                  cnt_pend = 1'b1;
               end
            end
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   task automatic wait_launch(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (valid_top) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One frame; cls < 0 means a random prediction, stall > 0 also offers the next image
   task automatic run_frame(input int lat, input int stall, input bit spur, input bit tmo, input int cls);
      logic ok;
      int   n;
      bit   pre;
      s_img   = pend_img;
      s_valid = 1'b1;
      wait_launch(ok);
      chk("accept_seen", ok, 1);
      if (!ok) return;
      exp_img.push_back(pend_img);
      chk("busy_launch", busy, 1);
      chk("s_ready_launch", s_ready, 0);
      pend_img = rand_img();
      s_valid  = 1'b0;
      s_img    = pend_img;
      if (spur) begin
         ready_top = 1'b1;
         number    = CLS_W'($urandom);
      end
      pre = bit'($urandom_range(0, 1));
      @(negedge clk);
      chk("valid_top_pulse", valid_top, 0);
      ready_top = 1'b0;
      if (tmo) begin
         exp_res.push_back('{cls: {CLS_W{1'b1}}, to: 1'b1});
         m_ready = (stall == 0) ? pre : 1'b0;
         for (int i = 0; i < TO_CYC; i++) begin
            chk("m_valid_before_timeout", m_valid, 0);
            @(negedge clk);
         end
         chk("m_valid_timeout", m_valid, 1);
         chk("m_class_timeout", m_class, {CLS_W{1'b1}});
      end else begin
         for (int i = 0; i < lat; i++) begin
            chk("m_valid_early", m_valid, 0);
            @(negedge clk);
         end
         n = (cls < 0) ? int'($urandom_range(0, (1 << CLS_W) - 1)) : cls;
         ready_top = 1'b1;
         number    = CLS_W'(n);
         exp_res.push_back('{cls: CLS_W'(n), to: 1'b0});
         m_ready = (stall == 0) ? pre : 1'b0;
         @(negedge clk);
         ready_top = 1'b0;
         number    = CLS_W'($urandom);
         chk("m_valid_latency", m_valid, 1);
      end
      if (stall > 0) begin
         s_valid = 1'b1;
         s_img   = pend_img;
         repeat (stall) @(negedge clk);
      end
      m_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!m_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("handshake_done", ok, 1);
      chk("s_ready_after", s_ready, 1);
      m_ready = bit'($urandom_range(0, 1));
   endtask

   task automatic spur_idle();
      ready_top = 1'b1;
      number    = CLS_W'($urandom);
      @(negedge clk);
      ready_top = 1'b0;
      chk("spur_idle_m_valid", m_valid, 0);
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_s_ready", s_ready, 1);
   endtask

   task automatic check_reset_vals();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_valid_top", valid_top, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_img_source", |img_source, 0);
      chk("rst_m_class", m_class, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
   endtask

   initial begin
      logic ok;
      int   st;
      pend_img = rand_img();
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst_n   = 1'b1;
      m_ready = 1'b1;

      run_frame(4, 0, 0, 0, 7);
      chk("first_frame_cnt", frame_cnt, 1);
      run_frame(3, 20, 0, 0, 7);
      run_frame(2, 0, 0, 0, -1);
      spur_idle();
      run_frame(0, 0, 1, 0, -1);

      // reset in the middle of WAIT, then a stale ready_top
      s_img   = pend_img;
      s_valid = 1'b1;
      wait_launch(ok);
      chk("mid_accept_seen", ok, 1);
      exp_img.push_back(pend_img);
      s_valid  = 1'b0;
      pend_img = rand_img();
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      ready_top = 1'b1;
      number    = 4'd5;
      @(negedge clk);
      ready_top = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_ready_m_valid", m_valid, 0);
         chk("late_ready_busy", busy, 0);
         @(negedge clk);
      end
      chk("late_ready_frame_cnt", frame_cnt, 0);

      for (int i = 0; i < 17; i++) begin
         st = (i == 16 || $urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(1, 4));
         if (!s_valid && $urandom_range(0, 3) == 0) spur_idle();
         run_frame((i == 0) ? TO_CYC - 1 : int'($urandom_range(0, TO_CYC - 1)), st,
                   bit'($urandom_range(0, 1)), 0, -1);
      end
      @(negedge clk);
      chk("frame_cnt_wrap", frame_cnt, 1);

`ifdef TCB_SCHED_TIMEOUT_EN
      run_frame(0, 2, 0, 1, -1);
      chk("timeout_sticky", timeout_err, 1);
      run_frame(1, 0, 0, 0, -1);
      chk("timeout_sticky_after", timeout_err, 1);
      rst_n = 1'b0;
      #1;
      chk("timeout_cleared", timeout_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_res.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish, %0d checks", checks);
      $fatal(1);
   end
endmodule
